// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared definitions for the serial link (Serializador /
//               Deserializador). Holds the frame-state encoding, the default
//               frame width and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

   // Default bits per frame, shared by both ends of the link.
   localparam int c_DATA_WIDTH_DEFAULT = 8;

   // Transmit frame states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } serial_state_t;

   // Width of a counter that must hold 0..w-1; never narrower than 1 bit so
   // degenerate sizes (w <= 1) still produce a legal vector.
   function automatic int serial_cnt_width(input int w);
      int r;
      r = $clog2(w);
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

   // Bit-counter width for the default frame width.
   localparam int c_CNT_WIDTH_DEFAULT = $clog2(c_DATA_WIDTH_DEFAULT);

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serializador.sv
`default_nettype none
// ============================================================================
// Module      : serializador
// Description : Parallel-to-serial transmitter. Accepts one word per
//               valid/ack handshake, shifts it out one bit per clock with
//               write_out framing each bit, inserts an inter-frame gap,
//               supports abort of a frame in flight and counts completed
//               frames.
// Ports       : clk           - transmit clock
//               reset         - synchronous active-high reset
//               data_in       - word to send, sampled on acceptance only
//               data_valid_in - source has a word on data_in
//               abort_in      - cancel the frame being shifted
//               ack_out       - one-cycle pulse, word accepted
//               data_out      - serial data bit
//               write_out     - high while data_out carries a frame bit
//               status_out    - 1 = busy (SHIFT or GAP), 0 = idle
//               frames_out    - completed-frame count, wraps 255 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module serializador
   import serial_pkg::*;
#(
   parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
   parameter int GAP_CYCLES = 2,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid_in,
   input  logic                  abort_in,
   output logic                  ack_out,
   output logic                  data_out,
   output logic                  write_out,
   output logic                  status_out,
   output logic [7:0]            frames_out
);

   localparam int c_CNT_W = serial_cnt_width(DATA_WIDTH);
   localparam int c_GAP_W = serial_cnt_width(GAP_CYCLES);

   // Bit index on data_out during the final frame cycle.
   localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);
   // Gap counter value during the final gap cycle.
   localparam logic [c_GAP_W-1:0] c_GAP_LAST =
      c_GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
   localparam bit c_HAS_GAP = (GAP_CYCLES > 0);

   serial_state_t         r_state;
   logic [DATA_WIDTH-1:0] r_shift;     // bits not yet placed on data_out
   logic [c_CNT_W-1:0]    r_bit_cnt;   // index of the bit currently on data_out
   logic [c_GAP_W-1:0]    r_gap_cnt;

   logic                  w_first_bit;
   logic [DATA_WIDTH-1:0] w_load_shift;
   logic                  w_next_bit;
   logic [DATA_WIDTH-1:0] w_next_shift;

   // The first bit goes straight to data_out on acceptance, so the shift
   // register is loaded already advanced by one position.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_first_bit  = data_in[DATA_WIDTH-1];
         assign w_load_shift = {data_in[DATA_WIDTH-2:0], 1'b0};
         assign w_next_bit   = r_shift[DATA_WIDTH-1];
         assign w_next_shift = {r_shift[DATA_WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_first_bit  = data_in[0];
         assign w_load_shift = {1'b0, data_in[DATA_WIDTH-1:1]};
         assign w_next_bit   = r_shift[0];
         assign w_next_shift = {1'b0, r_shift[DATA_WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_gap_cnt  <= '0;
         ack_out    <= 1'b0;
         data_out   <= 1'b0;
         write_out  <= 1'b0;
         status_out <= 1'b0;
         frames_out <= 8'd0;
      end else begin
         // ack is a single-cycle pulse; only an IDLE acceptance raises it.
         ack_out <= 1'b0;

         unique case (r_state)
            IDLE: begin
               if (data_valid_in) begin
                  r_shift    <= w_load_shift;
                  r_bit_cnt  <= '0;
                  data_out   <= w_first_bit;
                  write_out  <= 1'b1;
                  status_out <= 1'b1;
                  ack_out    <= 1'b1;
                  r_state    <= SHIFT;
               end
            end

            SHIFT: begin
               if (abort_in) begin
                  // Abort has priority over the last-bit edge: no count, no gap.
                  r_bit_cnt  <= '0;
                  data_out   <= 1'b0;
                  write_out  <= 1'b0;
                  status_out <= 1'b0;
                  r_state    <= IDLE;
               end else if (r_bit_cnt == c_LAST_BIT) begin
                  r_bit_cnt  <= '0;
                  data_out   <= 1'b0;
                  write_out  <= 1'b0;
                  frames_out <= frames_out + 8'd1;
                  if (c_HAS_GAP) begin
                     r_gap_cnt  <= '0;
                     status_out <= 1'b1;
                     r_state    <= GAP;
                  end else begin
                     status_out <= 1'b0;
                     r_state    <= IDLE;
                  end
               end else begin
                  data_out  <= w_next_bit;
                  r_shift   <= w_next_shift;
                  r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
               end
            end

            GAP: begin
               if (r_gap_cnt == c_GAP_LAST) begin
                  r_gap_cnt  <= '0;
                  status_out <= 1'b0;
                  r_state    <= IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
               end
            end

            default: begin
               r_bit_cnt  <= '0;
               r_gap_cnt  <= '0;
               data_out   <= 1'b0;
               write_out  <= 1'b0;
               status_out <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule : serializador
`default_nettype wire
